// File: rtl/tx_frame_packer.sv
// tx_frame_packer: packs AXI-Stream payload beats into fixed-width lane frames
// and serialises each frame MSB-first as RATIO = FRAME_WIDTH/DWIDTH words.
//
// Frame layout (FW = FRAME_WIDTH, PW = PAYLOAD_WIDTH):
//   [FW-1:FW-2]      FRAME_HDR
//   [FW-3:FW-4]      meta: 00 idle, 01 full non-EOP, 10 EOP partial, 11 EOP full
//   [FW-5 -: PW]     payload, byte 0 in the MSB position
//   [FW-5-PW:0]      CRC field, left zero for the downstream CRC inserter
//
// On an EOP-partial frame the last payload byte carries the valid byte count.
//
// Optional feature: define TX_KEEP_CHECK_EN to enable the sticky keep_err flag
// for illegal tkeep patterns. In that build the EOP byte count is the length of
// the leading-ones prefix of tkeep. Without the macro keep_err is tied low,
// tkeep is assumed legal and the count is popcount(tkeep).

module tx_frame_packer #(
  parameter int         DWIDTH        = 64,
  parameter int         FRAME_WIDTH   = 256,
  parameter int         PAYLOAD_WIDTH = 240,
  parameter logic [1:0] FRAME_HDR     = 2'b01
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PAYLOAD_WIDTH-1:0]   s_axis_tdata,
  input  logic [PAYLOAD_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       tx_pause,
  input  logic                       dout_ready,
  output logic [DWIDTH-1:0]          dout,
  output logic                       dout_sof,
  output logic                       keep_err
);

  localparam int RATIO = FRAME_WIDTH / DWIDTH;
  localparam int KW    = PAYLOAD_WIDTH / 8;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CRCW  = FRAME_WIDTH - 4 - PAYLOAD_WIDTH;

  localparam logic [CW-1:0]          CNT_LAST   = CW'(RATIO - 1);
  localparam logic [FRAME_WIDTH-1:0] IDLE_FRAME = {FRAME_HDR, {(FRAME_WIDTH-2){1'b0}}};

  logic [FRAME_WIDTH-1:0]   frame_reg;
  logic [FRAME_WIDTH-1:0]   frame_next;
  logic [CW-1:0]            cnt;
  logic                     load_en;
  logic                     accept;
  logic                     keep_full;
  logic [7:0]               eop_count;
  logic [1:0]               meta;
  logic [PAYLOAD_WIDTH-1:0] payload;

  // Frame boundary: the last word of the current frame is being consumed.
  assign load_en       = dout_ready && (cnt == CNT_LAST);
  assign s_axis_tready = load_en && !tx_pause;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign keep_full     = &s_axis_tkeep;

`ifdef TX_KEEP_CHECK_EN
  logic [7:0] keep_lead;
  logic       keep_gap;
  logic       keep_bad;

  // Length of the leading-ones prefix of tkeep, and whether any kept byte
  // follows a dropped one (non-contiguous from MSB).
  always_comb begin
    logic run;
    run       = 1'b1;
    keep_lead = '0;
    keep_gap  = 1'b0;
    for (int k = KW - 1; k >= 0; k--) begin
      run       = run & s_axis_tkeep[k];
      keep_lead = keep_lead + 8'(run);
      if (s_axis_tkeep[k] && !run)
        keep_gap = 1'b1;
    end
  end

  assign keep_bad  = keep_gap || (!s_axis_tlast && !keep_full);
  assign eop_count = keep_lead;

  // Sticky flag for any accepted beat carrying an illegal tkeep pattern.
  always_ff @(posedge clk) begin
    if (rst)
      keep_err <= 1'b0;
    else if (accept && keep_bad)
      keep_err <= 1'b1;
  end
`else
  logic [7:0] keep_pop;

  // Number of kept bytes; tkeep is trusted to be contiguous from MSB.
  always_comb begin
    keep_pop = '0;
    for (int k = 0; k < KW; k++)
      keep_pop = keep_pop + 8'(s_axis_tkeep[k]);
  end

  assign eop_count = keep_pop;
  assign keep_err  = 1'b0;
`endif

  // Assemble the next data frame: mask dropped bytes, pick meta, and place the
  // byte count in the last payload byte for a short final beat.
  always_comb begin
    payload = s_axis_tdata;
    for (int k = 0; k < KW; k++) begin
      if (!s_axis_tkeep[k])
        payload[8*k +: 8] = 8'h00;
    end
    if (!s_axis_tlast)
      meta = 2'b01;
    else if (keep_full)
      meta = 2'b11;
    else
      meta = 2'b10;
    if (meta == 2'b10)
      payload[7:0] = eop_count;
    frame_next = accept ? {FRAME_HDR, meta, payload, {CRCW{1'b0}}} : IDLE_FRAME;
  end

  // Frame register: reloads only at a frame boundary, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst)
      frame_reg <= IDLE_FRAME;
    else if (load_en)
      frame_reg <= frame_next;
  end

  generate
    if (RATIO > 1) begin : g_cnt
      // Word counter: advances on each consumed word, wraps at the frame end.
      always_ff @(posedge clk) begin
        if (rst)
          cnt <= '0;
        else if (dout_ready)
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end else begin : g_no_cnt
      assign cnt = '0;
    end
  endgenerate

  // Select the current word from the frame register, MSB slice first.
  always_comb begin
    dout = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt == CW'(i))
        dout = frame_reg[FRAME_WIDTH-1-i*DWIDTH -: DWIDTH];
    end
  end

  assign dout_sof = (cnt == '0);

endmodule

// File: tb/tb_tx_frame_packer.sv
// Testbench for tx_frame_packer: randomized AXIS traffic, lane back-pressure
// and pause, with a scoreboard of expected frames built from the frame rules.

module tb_tx_frame_packer;

  localparam int DW    = 64;
  localparam int FW    = 256;
  localparam int PW    = 240;
  localparam int KW    = PW / 8;
  localparam int RATIO = FW / DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          tx_pause;
  logic          dout_ready;
  logic [DW-1:0] dout;
  logic          dout_sof;
  logic          keep_err;

  always #5 clk = ~clk;

  tx_frame_packer #(
    .DWIDTH(DW), .FRAME_WIDTH(FW), .PAYLOAD_WIDTH(PW), .FRAME_HDR(2'b01)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .tx_pause(tx_pause),
    .dout_ready(dout_ready), .dout(dout), .dout_sof(dout_sof),
    .keep_err(keep_err)
  );

  // Owned by the monitor
  int            checks = 0;
  int            errors = 0;
  int            model_accepts = 0;
  int            wi = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] frame_acc;
  logic          exp_kerr;
  logic          prev_hold;
  logic [DW-1:0] prev_dout;
  logic          prev_sof;

  // Owned by the stimulus
  int  sent = 0;
  int  stim_to = 0;
  bit  rand_mode = 1'b0;
  bit  done = 1'b0;

  function automatic logic [FW-1:0] idle_frame();
    return {2'b01, {(FW-2){1'b0}}};
  endfunction

  // Expected frame for an accepted beat, from the byte-level frame rules.
  function automatic logic [FW-1:0] data_frame(input logic [PW-1:0] d,
                                               input logic [KW-1:0] k,
                                               input logic l);
    logic [7:0]    bytes [KW];
    logic [1:0]    meta;
    logic [PW-1:0] p;
    int            n;
    for (int i = 0; i < KW; i++)
      bytes[i] = k[KW-1-i] ? d[PW-1-8*i -: 8] : 8'h00;
    if (!l)                  meta = 2'b01;
    else if (k == {KW{1'b1}}) meta = 2'b11;
    else                     meta = 2'b10;
    if (meta == 2'b10) begin
`ifdef TX_KEEP_CHECK_EN
      n = 0;
      while (n < KW && k[KW-1-n]) n++;
`else
      n = $countones(k);
`endif
      bytes[KW-1] = 8'(n);
    end
    p = '0;
    for (int i = 0; i < KW; i++)
      p = {p[PW-9:0], bytes[i]};
    return {2'b01, meta, p, 12'h000};
  endfunction

  function automatic bit keep_illegal(input logic [KW-1:0] k, input logic l);
    int n;
    n = 0;
    while (n < KW && k[KW-1-n]) n++;
    return ($countones(k) != n) || (!l && n != KW);
  endfunction

  function automatic logic [PW-1:0] rand_data();
    logic [255:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  function automatic logic [KW-1:0] prefix_keep(input int n);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[KW-1-i] = 1'b1;
    return k;
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor and scoreboard: samples mid-cycle, reassembles consumed frames and
  // compares them with the queue of expected frames.
  always @(negedge clk) begin : monitor
    logic exp_rdy;
    if (done) begin
      chk("stimulus_timeouts", 32'(stim_to), 32'd0);
      chk("beats_accepted", 32'(model_accepts), 32'(sent));
      chk("queue_depth", 32'(exp_q.size()), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else if (rst) begin
      wi = 0;
      exp_q.delete();
      exp_q.push_back(idle_frame());
      exp_kerr = 1'b0;
      prev_hold = 1'b0;
    end else begin
      exp_rdy = dout_ready && (wi == RATIO - 1) && !tx_pause;
      chk("dout_sof", dout_sof, wi == 0);
      chk("tready", s_axis_tready, exp_rdy);
      chk("keep_err", keep_err, exp_kerr);
      if (prev_hold) begin
        chk("hold_dout", dout, prev_dout);
        chk("hold_sof", dout_sof, prev_sof);
      end
      if (dout_ready) begin
        frame_acc = {frame_acc[FW-DW-1:0], dout};
        if (wi == RATIO - 1) begin
          if (exp_q.size() == 0)
            chk("frame_queue_empty", 32'd0, 32'd1);
          else
            chk("frame", frame_acc, exp_q.pop_front());
          if (s_axis_tvalid && exp_rdy) begin
            exp_q.push_back(data_frame(s_axis_tdata, s_axis_tkeep, s_axis_tlast));
            model_accepts++;
`ifdef TX_KEEP_CHECK_EN
            if (keep_illegal(s_axis_tkeep, s_axis_tlast)) exp_kerr = 1'b1;
`endif
          end else begin
            exp_q.push_back(idle_frame());
          end
          wi = 0;
        end else begin
          wi++;
        end
      end
      prev_hold = !dout_ready;
      prev_dout = dout;
      prev_sof  = dout_sof;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (rand_mode) begin
      dout_ready = ($urandom % 4 != 0);
      tx_pause   = ($urandom % 10 == 0);
    end
  endtask

  // Present one beat and hold it until accepted; optionally pause first.
  task automatic send_beat(input logic [PW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input int pause_n);
    logic got;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    if (pause_n > 0) tx_pause = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      got = s_axis_tready;
      step();
      if (pause_n > 0 && cyc + 1 >= pause_n) tx_pause = 1'b0;
      if (got) begin
        s_axis_tvalid = 1'b0;
        sent++;
        return;
      end
    end
    stim_to++;
    $display("FAIL send_beat: beat not accepted, got no tready expected tready");
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_wi(input int v);
    for (int i = 0; i < 40; i++) begin
      if (wi == v) return;
      step();
    end
    stim_to++;
    $display("FAIL wait_wi: word index %0d expected %0d", wi, v);
  endtask

  task automatic random_beats(input int count);
    int n;
    for (int b = 0; b < count; b++) begin
      if ($urandom % 3 == 0) repeat ($urandom_range(1, 5)) step();
      if ($urandom % 3 == 0) begin
        n = $urandom_range(0, KW);
        send_beat(rand_data(), prefix_keep(n), 1'b1, 0);
      end else begin
        send_beat(rand_data(), {KW{1'b1}}, 1'b0, 0);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    tx_pause      = 1'b0;
    dout_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Idle frames after reset
    repeat (12) step();

    // Three-beat packet, full keep
    send_beat(rand_data(), {KW{1'b1}}, 1'b0, 0);
    send_beat(rand_data(), {KW{1'b1}}, 1'b0, 0);
    send_beat(rand_data(), {KW{1'b1}}, 1'b1, 0);

    // Partial EOP of 14 bytes, and an empty EOP
    send_beat(rand_data(), 30'h3FFF_0000, 1'b1, 0);
    send_beat(rand_data(), 30'h0000_0000, 1'b1, 0);
    send_beat(rand_data(), 30'h2000_0000, 1'b1, 0);
    repeat (8) step();

    // Pause raised mid-frame with a beat waiting
    wait_wi(1);
    send_beat(rand_data(), {KW{1'b1}}, 1'b1, 12);
    repeat (6) step();

`ifdef TX_KEEP_CHECK_EN
    send_beat(rand_data(), 30'h3FFF_FFFE, 1'b0, 0);
    repeat (10) step();
    send_beat(rand_data(), 30'h3F0F_0000, 1'b1, 0);
    repeat (6) step();
`endif

    // Random traffic with back-pressure and pauses
    rand_mode = 1'b1;
    random_beats(120);

    // Reset in the middle of a frame
    rand_mode  = 1'b0;
    dout_ready = 1'b1;
    tx_pause   = 1'b0;
    wait_wi(2);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();

    rand_mode = 1'b1;
    random_beats(60);

    // Drain
    rand_mode  = 1'b0;
    dout_ready = 1'b1;
    tx_pause   = 1'b0;
    repeat (20) step();
    done = 1'b1;
  end

endmodule
